// File: rtl/expr_stream_tx.sv
// expr_stream_tx: serialises a packed digit/operator request into an ASCII "d op d ... d" stream
module expr_stream_tx #(
    parameter int MAX_TERMS = 8,
    parameter int OPW = MAX_TERMS - 1
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [3:0]             n_terms,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [OPW-1:0]         ops,
    output logic [7:0]             out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam logic [3:0] MT = 4'(MAX_TERMS);
    typedef enum logic [1:0] {IDLE, EMIT_D, EMIT_OP} state_t;
    state_t state;
    logic [3:0] idx, nt_r;
    logic [4*MAX_TERMS-1:0] dig_r, dsh;
    logic [OPW-1:0] ops_r, osh;
    logic bad;
    always_comb begin
        bad = n_terms == 4'd0 || n_terms > MT;
        for (int i = 0; i < MAX_TERMS; i++)
            if (i < int'(n_terms) && digits[4*i +: 4] > 4'd9) bad = 1'b1;
        dsh = dig_r >> (4 * (int'(idx) + 1));
        osh = ops_r >> idx;
    end
    // dsh pre-selects the digit that follows the current operator
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            idx       <= 4'd0;
            nt_r      <= 4'd0;
            dig_r     <= '0;
            ops_r     <= '0;
            out       <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    dig_r <= digits;
                    ops_r <= ops;
                    nt_r  <= n_terms;
                    idx   <= 4'd0;
                    if (bad) err <= 1'b1;
                    else begin
                        state     <= EMIT_D;
                        out       <= 8'h30 + {4'h0, digits[3:0]};
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                EMIT_D: if (out_ready) begin
                    if (idx == nt_r - 4'd1) begin
                        state     <= IDLE;
                        out       <= 8'h00;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state <= EMIT_OP;
                        out   <= osh[0] ? 8'h2A : 8'h2B;
                    end
                end
                EMIT_OP: if (out_ready) begin
                    idx   <= idx + 4'd1;
                    state <= EMIT_D;
                    out   <= 8'h30 + {4'h0, dsh[3:0]};
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/expr_stream_tx.md
Name: expr_stream_tx

Overview:
- Transmit-side counterpart of the expression-string checker.
- Takes a packed request of single-digit operands and operators and emits it as an ASCII character stream, one character per accepted beat: "d op d op ... d".
- The stream feeds the checker's 8-bit character input, or a stall-capable sink via out_valid/out_ready.

Parameters:
- MAX_TERMS, 8, maximum number of operands per request (2..15).
- OPW, MAX_TERMS-1, derived: width of the operator vector.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- clr  input  1  reset. Asynchronous, active-high; clears all state immediately.
- start  input  1  request strobe, sampled only in IDLE.
- n_terms  input  4  number of operands in the request.
- digits  input  4*MAX_TERMS  operand i at [4i+3:4i], BCD 0..9.
- ops  input  OPW  operator between term i and i+1 at bit i: 0='+', 1='*'.
- out  output  8  current ASCII character; 8'h00 when not valid.
- out_valid  output  1  out holds a stream character.
- out_ready  input  1  sink accepts the character on this edge.
- busy  output  1  request in progress (EMIT_D or EMIT_OP).
- done  output  1  one-cycle pulse after the final character is accepted.
- err  output  1  one-cycle pulse for a rejected request.

Behaviour:
- Reset values: out=8'h00, out_valid=0, busy=0, done=0, err=0, state=IDLE, term index=0.
- All outputs are registered.
- States: IDLE, EMIT_D, EMIT_OP.
- Request capture (edge where state=IDLE and start=1):
  - digits, ops and n_terms are copied to internal registers.
  - Later changes on the request inputs have no effect until the next capture.
- Validation at capture:
  - The request is invalid if n_terms==0, n_terms>MAX_TERMS, or any digit among the first n_terms is >9.
  - Invalid: err=1 for exactly the next cycle, state stays IDLE, nothing is emitted.
  - Valid: state goes to EMIT_D with index=0.
- Latency: first character valid in the cycle after the start edge (1 cycle).
- EMIT_D:
  - out=8'h30+digit[index], out_valid=1.
  - On an edge with out_ready=1:
    - if index==n_terms-1, go to IDLE and pulse done;
    - otherwise go to EMIT_OP.
- EMIT_OP:
  - out=8'h2B if ops[index]==0, else 8'h2A; out_valid=1.
  - On an edge with out_ready=1: index increments, state goes to EMIT_D.
- Backpressure: while out_ready=0, out and out_valid hold unchanged; there are no skipped or duplicated characters.
- Stream length: exactly 2*n_terms-1 accepted beats per valid request.
  - n_terms==1 emits a single digit with no operator.
  - ops bits at index >= n_terms-1 are ignored.
- done:
  - Asserted for the single cycle after the last accepted beat.
  - out_valid=0 and busy=0 in that cycle.
  - A start in the done cycle is captured (back-to-back requests, 1 idle cycle between streams).
- start while busy is ignored; it is neither queued nor flagged.
- err and done are never asserted together.
- clr mid-stream: on clr assertion, the block returns to IDLE and out=8'h00/out_valid=0 without waiting for a clock; the interrupted request is discarded.
- out_ready is don't-care when out_valid=0.

Test Plan:
- Basic stream:
  - Stimulus: clr pulse, then start with n_terms=4, digits={1,2,1,1} (term0 first), ops=3'b000, out_ready=1.
  - Required: out sequence "1","+","2","+","1","+","1" (8'h31,2B,32,2B,31,2B,31) on 7 consecutive cycles starting 1 cycle after start; done pulse on the 8th; busy high for exactly 7 cycles.
- Mixed operators with stall:
  - Stimulus: n_terms=3, digits={1,9,0}, ops=2'b01, out_ready low for 3 cycles while "*" (8'h2A) is presented.
  - Required: full stream "1*9+0"; the "*" is held stable through the stall; no duplicate characters.
- Rejects:
  - Stimulus: separately, n_terms=0; n_terms=MAX_TERMS+1; and a valid count with digit[1]=4'hA.
  - Required: each gives an err pulse 1 cycle wide, out_valid never asserts, state stays IDLE.
- Single term and back-to-back:
  - Stimulus: n_terms=1, digit 7, then a second start asserted in the done cycle.
  - Required: single beat 8'h37, done, then the second stream begins on the next cycle.
- Reset mid-operation:
  - Stimulus: assert clr 2 ns after the 3rd character appears (between edges).
  - Required: out=8'h00, out_valid=0, busy=0 immediately; after release, a new start emits from term0.
- Start while busy:
  - Stimulus: pulse start with a different request during the 2nd beat.
  - Required: the original stream completes unchanged; no err; the second request is not emitted.
